// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and helpers for the oversampled UART receiver
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    localparam int MAX_DATA_BITS  = 9;
    localparam int MAX_FRAME_BITS = 1 + MAX_DATA_BITS + 1 + 2;

    // Expected parity bit for zero-extended data; odd=1 selects odd parity.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_term.sv
// rtl/uart_rx_term.sv - oversampled UART receiver with error flags and receive FIFO
module uart_rx_term
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(MAX_FRAME_BITS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV/2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);

    uart_rx_state_t          state;
    logic                    rx_meta, rx_s, rx_prev;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           bit_idx;
    logic [DATA_BITS-1:0]    shreg;
    logic [MAX_DATA_BITS-1:0] par_data;
    logic                    par_pend;
    logic                    push_req;
    logic                    fifo_empty;

    always_comb begin
        par_data = '0;
        par_data[DATA_BITS-1:0] = shreg;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_pend   <= 1'b0;
            push_req   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            push_req <= 1'b0;
            // Clears come first so that a same-cycle set below takes priority.
            if (clr_err) begin
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
                overrun    <= 1'b0;
            end
            if (push_req && fifo_full && !rd_en) overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state    <= ST_START;
                        cnt      <= HALF_LOAD;
                        bit_idx  <= '0;
                        par_pend <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (rx_s) state <= ST_IDLE;
                    else begin
                        cnt   <= BIT_LOAD;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        cnt   <= BIT_LOAD;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (int'(bit_idx) == DATA_BITS - 1) begin
                            bit_idx <= '0;
                            state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        cnt      <= BIT_LOAD;
                        par_pend <= (rx_s != parity_bit(par_data, 1'(PARITY_ODD)));
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (!rx_s) begin
                        frame_err <= 1'b1;
                        state     <= ST_BREAK;
                    end else if (int'(bit_idx) == STOP_BITS - 1) begin
                        push_req <= 1'b1;
                        if (par_pend) parity_err <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt     <= BIT_LOAD;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign rx_valid = ~fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push_req),
        .din   (shreg),
        .pop   (rd_en),
        .dout  (rx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: doc/uart_rx_term.md
Name: uart_rx_term

Overview:
- Synthesizable, parametrised successor to the bench-level serial terminal that watches a UART TX line.
- Oversampled UART receiver with configurable frame format (data bits, parity, stop bits) and an internal receive FIFO.
- Detects false starts, framing errors, parity errors and overrun.
- Used on-chip as a loopback/debug receiver on RsTx/RsRx lines, and in benches as a checkable replacement for the behavioural terminal.

Parameters:
- CLK_DIV, 16, HCLK cycles per bit; legal values are 4..65535.
- DATA_BITS, 8, data bits per frame; legal values are 5..9, LSB first.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits checked; legal values are 1 or 2.
- FIFO_DEPTH, 16, receive FIFO entries; must be a power of two, at least 2.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, asynchronous to HCLK, idle high.
- rd_en  in  1  pop the FIFO head; ignored when empty.
- clr_err  in  1  clear all sticky error flags.
- rx_data  out  DATA_BITS  FIFO head (show-ahead); 0 when empty.
- rx_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- frame_err  out  1  sticky: a stop bit was sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- busy  out  1  receiver FSM is not in IDLE.

Behaviour:
- Clock and reset:
  - Single clock, HCLK.
  - HRESET is asynchronous and active-high.
  - Every register, including the synchroniser, resets immediately on HRESET.
  - Reset values: all outputs 0; synchroniser flops reset to 1 (idle).
- Input conditioning: rx passes through a 2-flop synchroniser (rx_s); start detection uses the previous rx_s sample.
- Bit timing:
  - cnt is a down-counter of $clog2(CLK_DIV) bits.
  - Sample points fall at CLK_DIV/2 cycles after start detect, then every CLK_DIV cycles after that.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - A falling edge on rx_s (previous 1, current 0) moves to START.
  - On that transition, load cnt = CLK_DIV/2 - 1.
- START:
  - At cnt==0, sample rx_s.
  - If the sample is 1, this is a false start: return to IDLE, with no flags and no push.
  - If the sample is 0, reload cnt = CLK_DIV-1 and go to DATA.
- DATA:
  - Shift rx_s into the shift register LSB-first at each sample point.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY:
  - Sample the parity bit.
  - Expected parity = XOR of the data bits, XORed with PARITY_ODD.
  - Record a mismatch in a pending flag.
- STOP:
  - Sample STOP_BITS bits.
  - If any stop bit is low: discard the frame, set frame_err, go to BREAK.
  - If all stop bits are high: request a push, set parity_err if the pending flag is set, go to IDLE.
- BREAK: wait for rx_s==1, then go to IDLE. The receiver does not restart while the line is held low.
- Push timing and latency:
  - The push happens on the cycle after the final stop-bit sample.
  - rx_valid rises the following cycle.
  - Latency from the rx falling edge to rx_valid is 2 + CLK_DIV/2 + (DATA_BITS + PARITY_EN + STOP_BITS)*CLK_DIV + 2 cycles, ±1.
- FIFO:
  - Synchronous, show-ahead.
  - Pop on rd_en when not empty.
  - Push and pop in the same cycle both succeed, including when full: fifo_count is unchanged and ordering is preserved.
  - A push when full with no pop drops the new frame, sets overrun, and leaves the FIFO contents intact.
  - rd_en on an empty FIFO has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clr_err clears all three flags. If a new error occurs in the same cycle as clr_err, the flag ends up set (set wins).
- Reset mid-frame: the partial frame is discarded, the FSM returns to IDLE, and the FIFO is emptied.
- busy is high in every state except IDLE.

Decomposition:
- Package uart_rx_pkg:
  - FSM state enum (uart_rx_state_t).
  - Parity helper function.
  - Localparam for the frame bit count.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; provides count, full and empty.
- uart_rx_term instantiates sync_fifo with WIDTH = DATA_BITS.

Test Plan:
All scenarios use CLK_DIV=16 and HCLK at 10 ns, i.e. a 160 ns bit time.
- Reset, then send 0x55 in 8N1 -> rx_valid=1, rx_data=0x55, fifo_count=1; after rd_en, rx_valid=0 and rx_data=0.
- Pull rx low for 4 cycles, then release -> no push, busy returns low within 9 cycles, no error flags set.
- Send 0xA3 with the stop bit held low for 3 bit times -> frame_err=1, fifo_count=0. After rx goes high, 0x3C is received correctly. clr_err then clears frame_err.
- Send 17 frames 0x00..0x10 with rd_en=0 and FIFO_DEPTH=16 -> fifo_full=1, overrun=1, fifo_count=16. Draining returns 0x00..0x0F in order.
- With PARITY_EN=1 and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1, and 0x07 is still pushed. With a correct parity bit (1), parity_err stays 0.
- Assert HRESET during the 4th data bit of a frame -> all outputs 0 immediately. The next complete frame, 0xF0, is received correctly with fifo_count=1.
